// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-step radix-2 shift-add core, five rounding modes.
// Optional macro FP_MUL_SUBNORMAL_EN adds a PRENORM state that normalises subnormal operands.
module fp_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Num_A,
    input  logic [31:0] Num_B,
    input  logic [2:0]  R_M,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        OverFlow
);

`ifdef FP_MUL_SUBNORMAL_EN
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_PRENORM, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;
    localparam state_t S_FIRST = S_PRENORM;
`else
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;
    localparam state_t S_FIRST = S_UNPACK;
`endif

    state_t             r_state, w_next;
    logic [31:0]        r_a, r_b, r_result;
    logic [2:0]         r_rm;
    logic               r_sign, r_of, r_g, r_r, r_s;
    logic signed [9:0]  r_exp;
    logic [4:0]         r_cnt;
    logic [47:0]        r_acc, r_mcand;
    logic [23:0]        r_mplier, r_mant;

    logic [7:0]         w_ea, w_eb;
    logic [22:0]        w_fa, w_fb;
    logic               w_sign, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_special;
    logic [9:0]         w_ea_eff, w_eb_eff;
    logic signed [9:0]  w_exp_sum;
    logic [23:0]        w_sig_a, w_sig_b, w_first_ma, w_first_mb;
    logic [31:0]        w_spec_res;

    assign w_ea      = r_a[30:23];
    assign w_eb      = r_b[30:23];
    assign w_fa      = r_a[22:0];
    assign w_fb      = r_b[22:0];
    assign w_sign    = r_a[31] ^ r_b[31];
    assign w_a_nan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
`ifdef FP_MUL_SUBNORMAL_EN
    assign w_a_zero  = (w_ea == 8'd0) && (w_fa == 23'd0);
    assign w_b_zero  = (w_eb == 8'd0) && (w_fb == 23'd0);
`else
    assign w_a_zero  = (w_ea == 8'd0);
    assign w_b_zero  = (w_eb == 8'd0);
`endif
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

    // Subnormals carry the same scale as exponent 1; only the hidden bit differs.
    assign w_ea_eff  = (w_ea == 8'd0) ? 10'd1 : {2'b00, w_ea};
    assign w_eb_eff  = (w_eb == 8'd0) ? 10'd1 : {2'b00, w_eb};
    assign w_exp_sum = $signed(w_ea_eff) + $signed(w_eb_eff) - 10'sd127;
    assign w_sig_a   = {(w_ea != 8'd0), w_fa};
    assign w_sig_b   = {(w_eb != 8'd0), w_fb};

`ifdef FP_MUL_SUBNORMAL_EN
    function automatic logic [4:0] f_lzc(input logic [23:0] v);
        logic found;
        f_lzc = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      f_lzc = f_lzc + 5'd1;
            end
        end
    endfunction

    logic [4:0] w_lz_a, w_lz_b;
    assign w_lz_a     = f_lzc(w_sig_a);
    assign w_lz_b     = f_lzc(w_sig_b);
    assign w_first_ma = w_sig_a << w_lz_a;
    assign w_first_mb = w_sig_b << w_lz_b;
`else
    assign w_first_ma = w_sig_a;
    assign w_first_mb = w_sig_b;
`endif

    always_comb begin
        w_spec_res = {w_sign, 31'd0};
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero))
            w_spec_res = 32'h7FC0_0000;
        else if (w_a_inf | w_b_inf)
            w_spec_res = {w_sign, 8'hFF, 23'd0};
    end

    logic [46:0] w_norm;
    logic        w_lost;
    assign w_norm = r_acc[47] ? r_acc[47:1] : r_acc[46:0];
    assign w_lost = r_acc[47] & r_acc[0];

    logic              w_inexact, w_inc, w_rnd_of;
    logic [24:0]       w_mant_rnd;
    logic signed [9:0] w_exp_rnd;
    logic [22:0]       w_frac;
    logic [31:0]       w_rnd_res;

    assign w_inexact = r_g | r_r | r_s;

    always_comb begin
        case (r_rm)
            3'b001:  w_inc = 1'b0;
            3'b010:  w_inc = w_inexact & r_sign;
            3'b011:  w_inc = w_inexact & ~r_sign;
            3'b100:  w_inc = r_g;
            default: w_inc = r_g & (r_r | r_s | r_mant[0]);
        endcase
        w_mant_rnd = {1'b0, r_mant} + {24'd0, w_inc};
        w_exp_rnd  = r_exp + $signed({9'd0, w_mant_rnd[24]});
        w_frac     = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
        w_rnd_of   = 1'b0;
        w_rnd_res  = {r_sign, w_exp_rnd[7:0], w_frac};
        if (w_exp_rnd > 10'sd254) begin
            w_rnd_of = 1'b1;
            case (r_rm)
                3'b001:  w_rnd_res = {r_sign, 31'h7F7F_FFFF};
                3'b010:  w_rnd_res = r_sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                3'b011:  w_rnd_res = r_sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
                default: w_rnd_res = {r_sign, 8'hFF, 23'd0};
            endcase
        end else if (w_exp_rnd <= 10'sd0) begin
            w_rnd_res = {r_sign, 31'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_UNPACK;
            end
`ifdef FP_MUL_SUBNORMAL_EN
            S_UNPACK:  w_next = w_special ? S_DONE : S_PRENORM;
            S_PRENORM: w_next = S_MUL;
`else
            S_UNPACK:  w_next = w_special ? S_DONE : S_MUL;
`endif
            S_MUL:     if (r_cnt == 5'd23) w_next = S_NORM;
            S_NORM:    w_next = S_ROUND;
            S_ROUND:   w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // The first shift-add step overlaps the state before MUL, so 24 steps finish as r_cnt reaches 23.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= 48'd0;
            r_mcand  <= 48'd0;
            r_mplier <= 24'd0;
            r_cnt    <= 5'd0;
        end else if (r_state == S_FIRST) begin
            r_acc    <= w_first_mb[0] ? {24'd0, w_first_ma} : 48'd0;
            r_mcand  <= {23'd0, w_first_ma, 1'b0};
            r_mplier <= {1'b0, w_first_mb[23:1]};
            r_cnt    <= 5'd1;
        end else if (r_state == S_MUL) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= (r_cnt == 5'd23) ? 5'd0 : r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rm     <= 3'd0;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_mant   <= 24'd0;
            r_g      <= 1'b0;
            r_r      <= 1'b0;
            r_s      <= 1'b0;
            r_result <= 32'd0;
            r_of     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a  <= Num_A;
                    r_b  <= Num_B;
                    r_rm <= R_M;
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp_sum;
                    r_of   <= 1'b0;
                    if (w_special) r_result <= w_spec_res;
                end
`ifdef FP_MUL_SUBNORMAL_EN
                S_PRENORM: r_exp <= r_exp - $signed({5'd0, w_lz_a}) - $signed({5'd0, w_lz_b});
`endif
                S_NORM: begin
                    r_exp  <= r_exp + $signed({9'd0, r_acc[47]});
                    r_mant <= w_norm[46:23];
                    r_g    <= w_norm[22];
                    r_r    <= w_norm[21];
                    r_s    <= (|w_norm[20:0]) | w_lost;
                end
                S_ROUND: begin
                    r_result <= w_rnd_res;
                    r_of     <= w_rnd_of;
                end
                default: ;
            endcase
        end
    end

    assign Result   = r_result;
    assign OverFlow = r_of;

endmodule
